// File: rtl/sft_sched.sv
// Serial frame scheduler for a 16-bit 595-style shift-register chain.
// Shadow LED/aux images are shifted MSB first whenever either is dirty.
module sft_sched #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       led_vld,
  input  logic [7:0] led_din,
  input  logic       aux_vld,
  input  logic [7:0] aux_din,
  output logic       busy,
  output logic       done,
  output logic       sft_shcp,
  output logic       sft_stcp,
  output logic       sft_ds
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  led_img, aux_img;
  logic        led_dirty, aux_dirty;
  logic [15:0] frame_sr, sr_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic [3:0]  bit_cnt, bit_nxt;
  logic        shcp_nxt;
  logic        load;
  logic        div_end;

  assign div_end = (div_cnt == DIV_M1);

  always_comb begin
    state_nxt = state;
    sr_nxt    = frame_sr;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shcp_nxt  = sft_shcp;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (led_dirty | aux_dirty)
          state_nxt = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        sr_nxt    = {aux_img, led_img};
        div_nxt   = 8'd0;
        bit_nxt   = 4'd0;
        shcp_nxt  = 1'b0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (div_end) begin
          div_nxt = 8'd0;
          if (!sft_shcp) begin
            shcp_nxt = 1'b1;
          end else begin
            shcp_nxt = 1'b0;
            sr_nxt   = {frame_sr[14:0], 1'b0};
            bit_nxt  = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15)
              state_nxt = LATCH;
          end
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      LATCH: begin
        if (div_end) begin
          div_nxt   = 8'd0;
          state_nxt = IDLE;
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      frame_sr <= 16'd0;
      div_cnt  <= 8'd0;
      bit_cnt  <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sft_shcp <= 1'b0;
      sft_stcp <= 1'b0;
      sft_ds   <= 1'b0;
    end else begin
      state    <= state_nxt;
      frame_sr <= sr_nxt;
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= (state == LATCH) && (state_nxt == IDLE);
      sft_shcp <= shcp_nxt;
      sft_stcp <= (state_nxt == LATCH);
      sft_ds   <= (state_nxt == SHIFT) & sr_nxt[15];
    end
  end

  // A strobe landing on LOAD keeps its dirty flag: set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_img   <= 8'd0;
      aux_img   <= 8'd0;
      led_dirty <= 1'b1;
      aux_dirty <= 1'b1;
    end else begin
      if (led_vld)
        led_img <= led_din;
      if (aux_vld)
        aux_img <= aux_din;
      if (led_vld)
        led_dirty <= 1'b1;
      else if (load)
        led_dirty <= 1'b0;
      if (aux_vld)
        aux_dirty <= 1'b1;
      else if (load)
        aux_dirty <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sft_sched.sv
// Scoreboard bench for sft_sched: DIV=4 and DIV=1 instances,
// frames rebuilt from sft_ds on rising sft_shcp and checked at sft_stcp.
module tb_sft_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n, led_vld, aux_vld;
  logic [1:0] busy, done, shcp, stcp, ds;
  logic [7:0] led_din [2];
  logic [7:0] aux_din [2];

  sft_sched #(.DIV(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n[0]),
    .led_vld  (led_vld[0]),
    .led_din  (led_din[0]),
    .aux_vld  (aux_vld[0]),
    .aux_din  (aux_din[0]),
    .busy     (busy[0]),
    .done     (done[0]),
    .sft_shcp (shcp[0]),
    .sft_stcp (stcp[0]),
    .sft_ds   (ds[0])
  );

  sft_sched #(.DIV(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n[1]),
    .led_vld  (led_vld[1]),
    .led_din  (led_din[1]),
    .aux_vld  (aux_vld[1]),
    .aux_din  (aux_din[1]),
    .busy     (busy[1]),
    .done     (done[1]),
    .sft_shcp (shcp[1]),
    .sft_stcp (stcp[1]),
    .sft_ds   (ds[1])
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [7:0]  led_m [2];
  logic [7:0]  aux_m [2];
  int          bits [2];
  int          stcp_len [2];
  int          busy_len [2];
  int          done_cnt [2];
  logic [15:0] got [2];
  logic [15:0] exp_f;
  logic [1:0]  shcp_p, stcp_p, busy_p, done_p, after_done;

  function automatic int divv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        bits[i]     = 0;
        stcp_len[i] = 0;
        busy_len[i] = 0;
      end else begin
        if (shcp[i] & stcp[i])
          chk($sformatf("shcp_stcp_excl%0d", i), 1, 0);
        if (done[i] & busy[i])
          chk($sformatf("done_busy_excl%0d", i), 1, 0);
        if (done_p[i])
          after_done[i] = busy[i];
        if (shcp[i] && !shcp_p[i]) begin
          got[i] = {got[i][14:0], ds[i]};
          bits[i]++;
        end
        if (stcp[i])
          stcp_len[i]++;
        if (stcp_p[i] && !stcp[i]) begin
          chk($sformatf("stcp_len%0d", i), stcp_len[i], divv(i));
          chk($sformatf("bit_count%0d", i), bits[i], 16);
          if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            chk($sformatf("unexpected_frame%0d", i), 1, 0);
          end else begin
            exp_f = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("frame%0d", i), got[i], exp_f);
          end
          bits[i]     = 0;
          stcp_len[i] = 0;
        end
        if (busy[i]) begin
          busy_len[i]++;
        end else if (busy_p[i]) begin
          chk($sformatf("busy_len%0d", i), busy_len[i], 1 + 33 * divv(i));
          busy_len[i] = 0;
        end
        if (done[i])
          done_cnt[i]++;
      end
      shcp_p[i] = shcp[i];
      stcp_p[i] = stcp[i];
      busy_p[i] = busy[i];
      done_p[i] = done[i];
    end
  end

  task automatic push(input int i);
    if (i == 0)
      q0.push_back({aux_m[0], led_m[0]});
    else
      q1.push_back({aux_m[1], led_m[1]});
  endtask

  task automatic strobe(input int i, input logic lv, input logic [7:0] ld,
                        input logic av, input logic [7:0] ad);
    @(posedge clk);
    #1;
    led_vld[i] = lv;
    led_din[i] = ld;
    aux_vld[i] = av;
    aux_din[i] = ad;
    if (lv) led_m[i] = ld;
    if (av) aux_m[i] = ad;
    push(i);
    @(posedge clk);
    #1;
    led_vld[i] = 1'b0;
    aux_vld[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int n);
    int t = 0;
    while (done_cnt[i] < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk($sformatf("wait_done%0d_%0d", i, n), 32'(done_cnt[i] >= n), 1);
  endtask

  task automatic wait_bits(input int i, input int n);
    int t = 0;
    while (bits[i] < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk($sformatf("wait_bits%0d_%0d", i, n), 32'(bits[i] >= n), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 2'b00;
    led_vld = 2'b00;
    aux_vld = 2'b00;
    shcp_p  = 2'b00;
    stcp_p  = 2'b00;
    busy_p  = 2'b00;
    done_p  = 2'b00;
    after_done = 2'b00;
    exp_f   = 16'd0;
    for (int i = 0; i < 2; i++) begin
      led_din[i]  = 8'd0;
      aux_din[i]  = 8'd0;
      led_m[i]    = 8'd0;
      aux_m[i]    = 8'd0;
      bits[i]     = 0;
      stcp_len[i] = 0;
      busy_len[i] = 0;
      done_cnt[i] = 0;
      got[i]      = 16'd0;
    end

    idle(3);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_shcp", shcp[0], 0);
    chk("rst_stcp", stcp[0], 0);
    chk("rst_ds", ds[0], 0);

    push(0);
    push(1);
    rst_n = 2'b11;
    wait_done(0, 1);
    wait_done(1, 1);
    idle(5);
    chk("zero_frame_idle", busy[0], 0);
    chk("zero_frame_no_refire", after_done[0], 0);
    chk("zero_frame_dones", done_cnt[0], 1);

    strobe(0, 1'b1, 8'hA5, 1'b0, 8'h00);
    wait_done(0, 2);
    idle(5);
    chk("a5_dones", done_cnt[0], 2);

    strobe(0, 1'b1, 8'h0F, 1'b1, 8'hC3);
    wait_done(0, 3);
    idle(5);
    chk("c30f_single_done", done_cnt[0], 3);

    strobe(0, 1'b1, 8'h01, 1'b1, 8'h00);
    wait_bits(0, 3);
    strobe(0, 1'b1, 8'h02, 1'b0, 8'h00);
    wait_done(0, 4);
    idle(1);
    chk("back_to_back_busy", after_done[0], 1);
    wait_done(0, 5);
    idle(5);
    chk("two_frame_dones", done_cnt[0], 5);
    chk("two_frame_no_refire", after_done[0], 0);

    strobe(0, 1'b1, 8'h5A, 1'b0, 8'h00);
    wait_bits(0, 7);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    q0.delete();
    led_m[0] = 8'd0;
    aux_m[0] = 8'd0;
    #1;
    chk("abort_shcp", shcp[0], 0);
    chk("abort_stcp", stcp[0], 0);
    chk("abort_ds", ds[0], 0);
    chk("abort_busy", busy[0], 0);
    idle(3);
    push(0);
    rst_n[0] = 1'b1;
    wait_done(0, 6);
    idle(5);
    chk("abort_dones", done_cnt[0], 6);

    strobe(1, 1'b1, 8'h3C, 1'b1, 8'h81);
    wait_done(1, 2);
    idle(5);
    chk("div1_dones", done_cnt[1], 2);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
